// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a paced launch FSM.
// Launches wait for tx_busy to fall; a launch the transmitter never acknowledges is flagged.
module uart_tx_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int BUSY_TO = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              launch_err,
  input  logic              err_clr,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [15:0]       TO_LAST  = 16'(BUSY_TO - 1);

  state_t state;
  state_t state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_n;
  logic [15:0]       to_cnt;

  logic push;
  logic pop;
  logic ovf_set;
  logic to_hit;

  // full is the registered flag, so a same-cycle pop never rescues a push
  assign push    = wr_en && !full;
  assign ovf_set = wr_en && full;
  assign pop     = (state == IDLE) && !empty && !tx_busy;
  assign to_hit  = (state == WAIT_BUSY) && !tx_busy
                && (to_cnt == TO_LAST);

  assign tx_start = (state == LAUNCH);
  assign count    = cnt_q;

  always_comb begin
    cnt_n = cnt_q;
    if (push && !pop)
      cnt_n = cnt_q + CNT_ONE;
    else if (pop && !push)
      cnt_n = cnt_q - CNT_ONE;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (pop)
          state_n = LAUNCH;
      end
      LAUNCH: begin
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)
          state_n = WAIT_DONE;
        else if (to_cnt == TO_LAST)
          state_n = IDLE;
      end
      WAIT_DONE: begin
        if (!tx_busy)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // storage is not reset; only the pointers are
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      cnt_q <= cnt_n;
      empty <= (cnt_n == '0);
      full  <= (cnt_n == FULL_CNT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_data <= '0;
      to_cnt  <= '0;
    end else begin
      state <= state_n;
      if (pop)
        tx_data <= mem[rd_ptr];
      if (state == LAUNCH)
        to_cnt <= '0;
      else if ((state == WAIT_BUSY) && !tx_busy && !to_hit)
        to_cnt <= to_cnt + 16'd1;
    end
  end

  // a set event in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      launch_err <= 1'b0;
    end else begin
      if (ovf_set)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (to_hit)
        launch_err <= 1'b1;
      else if (err_clr)
        launch_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter busy model.
// The DUT runs with a short launch timeout so the error path is reachable.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       launch_err;
  logic       err_clr;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  logic       model_en;
  logic       model_busy;
  logic       ext_busy;
  int         busy_len;
  int         busy_left;
  logic [7:0] tx_log [$];

  int n_chk  = 0;
  int n_fail = 0;

  assign tx_busy = model_busy | ext_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W (8),
    .DEPTH  (16),
    .ADDR_W (4),
    .BUSY_TO(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .launch_err(launch_err),
    .err_clr   (err_clr),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy)
  );

  // transmitter: busy from the cycle after tx_start for busy_len cycles
  initial begin
    model_busy = 1'b0;
    busy_left  = 0;
  end

  always @(posedge clk) begin
    if (tx_start)
      tx_log.push_back(tx_data);
    if (model_en && tx_start) begin
      model_busy <= 1'b1;
      busy_left  <= busy_len - 1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else begin
      model_busy <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, tx_log.size(), n);
  endtask

  task automatic settle();
    int k = 0;
    while (tx_busy && k < 200) begin
      tick();
      k++;
    end
    chk("settle_busy", int'(tx_busy), 0);
    repeat (3) tick();
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    err_clr  = 1'b0;
    ext_busy = 1'b0;
    model_en = 1'b1;
    busy_len = 20;
    repeat (3) tick();

    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_lerr", int'(launch_err), 0);
    chk("rst_start", int'(tx_start), 0);
    chk("rst_data", int'(tx_data), 0);
    reset_n = 1'b1;
    tick();

    // single byte, two-cycle launch latency
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("t1_start0", int'(tx_start), 0);
    chk("t1_count1", int'(count), 1);
    chk("t1_empty0", int'(empty), 0);
    tick();
    chk("t1_start1", int'(tx_start), 1);
    chk("t1_data", int'(tx_data), 8'hA5);
    chk("t1_empty1", int'(empty), 1);
    tick();
    chk("t1_start_once", int'(tx_start), 0);
    settle();
    chk("t1_log_n", tx_log.size(), 1);
    chk("t1_log0", int'(tx_log[0]), 8'hA5);

    // fill while transmitter busy, overflow, err_clr priority
    ext_busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
      if (i == 8)
        chk("t2_count8", int'(count), 8);
    end
    chk("t2_full", int'(full), 1);
    chk("t2_count16", int'(count), 16);
    chk("t2_ovf0", int'(overflow), 0);
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    chk("t2_ovf1", int'(overflow), 1);
    chk("t2_count_hold", int'(count), 16);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6_clr", int'(overflow), 0);
    wr_en   = 1'b1;
    wr_data = 8'h12;
    err_clr = 1'b1;
    tick();
    wr_en   = 1'b0;
    err_clr = 1'b0;
    chk("t6_set_wins", int'(overflow), 1);
    chk("t2_no_launch", tx_log.size(), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6_clr2", int'(overflow), 0);
    ext_busy = 1'b0;
    wait_log(17, 800, "t2_drain_n");
    settle();
    chk("t2_log_n", tx_log.size(), 17);
    for (int i = 1; i <= 16; i++)
      chk("t2_order", int'(tx_log[i]), i);
    chk("t2_empty", int'(empty), 1);

    // launch timeout with the transmitter silent
    model_en = 1'b0;
    wr_en    = 1'b1;
    wr_data  = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    chk("t3_start", int'(tx_start), 1);
    repeat (8) tick();
    chk("t3_lerr0", int'(launch_err), 0);
    tick();
    chk("t3_lerr1", int'(launch_err), 1);
    chk("t3_empty", int'(empty), 1);
    repeat (5) tick();
    chk("t3_one_pulse", tx_log.size(), 18);
    chk("t3_log", int'(tx_log[17]), 8'h3C);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_clr", int'(launch_err), 0);

    // interleaved push and drain across pointer wrap
    model_en = 1'b1;
    busy_len = 3;
    for (int i = 0; i < 20; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h40 + i);
      tick();
      wr_en = 1'b0;
      repeat (2) tick();
    end
    wait_log(38, 400, "t4_drain_n");
    settle();
    repeat (10) tick();
    chk("t4_log_n", tx_log.size(), 38);
    for (int i = 0; i < 20; i++)
      chk("t4_order", int'(tx_log[18+i]), 8'h40 + i);
    chk("t4_ovf", int'(overflow), 0);

    // reset while a frame is in flight
    busy_len = 20;
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h60 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("t5_count5", int'(count), 5);
    repeat (4) tick();
    chk("t5_inflight", tx_log.size(), 39);
    reset_n = 1'b0;
    #1;
    chk("t5_count", int'(count), 0);
    chk("t5_empty", int'(empty), 1);
    chk("t5_start", int'(tx_start), 0);
    chk("t5_data", int'(tx_data), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (40) tick();
    chk("t5_quiet", tx_log.size(), 39);
    wr_en   = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    wait_log(40, 100, "t5_new_n");
    chk("t5_new", int'(tx_log[tx_log.size()-1]), 8'h77);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
